// File: rtl/branch_ext_forward_if.sv
// Decode-stage operand bus: forwarding sources, register reads, immediate,
// branch select and the combinational plus captured results.
`default_nettype none

interface branch_ext_forward_if;
    logic [37:0] MEM_BACK;
    logic [37:0] WB_BACK;
    logic        USE_MEM_BACK;
    logic        USE_WB_BACK;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic        extop;
    logic        exsign;
    logic [2:0]  branchType;
    logic        en;
    logic        flush;
    logic [31:0] f_rd1;
    logic [31:0] f_rd2;
    logic [31:0] ext_b;
    logic        branchAvail;
    logic [31:0] q_rd1;
    logic [31:0] q_rd2;
    logic [31:0] q_ext;
    logic        q_branchAvail;

    modport slave (
        input  MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK, rs, rt, rd1, rd2,
               imm, extop, exsign, branchType, en, flush,
        output f_rd1, f_rd2, ext_b, branchAvail,
               q_rd1, q_rd2, q_ext, q_branchAvail
    );

    modport master (
        output MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK, rs, rt, rd1, rd2,
               imm, extop, exsign, branchType, en, flush,
        input  f_rd1, f_rd2, ext_b, branchAvail,
               q_rd1, q_rd2, q_ext, q_branchAvail
    );
endinterface

`default_nettype wire

// File: rtl/branch_ext_forward.sv
// Decode-stage operand unit: MEM/WB forwarding, immediate extension, branch
// condition evaluation, and an ID/EX capture register with stall/flush.
`default_nettype none

module branch_ext_forward (
    input  wire logic               clk,
    input  wire logic               rst,
    branch_ext_forward_if.slave     bus
);
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;

    logic [31:0] fwd1, fwd2, ext;
    logic        br;
    logic [31:0] rd1_q, rd2_q, ext_q;
    logic [31:0] rd1_d, rd2_d, ext_d;
    logic        br_q, br_d;

    // MEM wins over WB; register 0 is hard-wired and never forwarded.
    function automatic logic [31:0] forward(
        input logic [4:0]  r,
        input logic [31:0] raw,
        input logic [37:0] mem,
        input logic        use_mem,
        input logic [37:0] wb,
        input logic        use_wb
    );
        logic [31:0] v;
        v = raw;
        if (r != 5'd0) begin
            if (use_mem && mem[37] && (mem[4:0] == r))
                v = mem[36:5];
            else if (use_wb && wb[37] && (wb[4:0] == r))
                v = wb[36:5];
        end
        return v;
    endfunction

    always_comb begin
        fwd1 = forward(bus.rs, bus.rd1, bus.MEM_BACK, bus.USE_MEM_BACK,
                       bus.WB_BACK, bus.USE_WB_BACK);
        fwd2 = forward(bus.rt, bus.rd2, bus.MEM_BACK, bus.USE_MEM_BACK,
                       bus.WB_BACK, bus.USE_WB_BACK);
    end

    always_comb begin
        ext = {16'h0000, bus.imm};
        if (bus.extop)
            ext = {bus.imm, 16'h0000};
        else if (bus.exsign)
            ext = {{16{bus.imm[15]}}, bus.imm};
    end

    always_comb begin
        br = 1'b0;
        case (bus.branchType)
            BR_BEQ:  br = (fwd1 == fwd2);
            BR_BNE:  br = (fwd1 != fwd2);
            BR_BLEZ: br = fwd1[31] || (fwd1 == 32'd0);
            BR_BGTZ: br = !fwd1[31] && (fwd1 != 32'd0);
            BR_BLTZ: br = fwd1[31];
            BR_BGEZ: br = !fwd1[31];
            default: br = 1'b0;
        endcase
    end

    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        ext_d = ext_q;
        br_d  = br_q;
        if (bus.flush) begin
            rd1_d = 32'd0;
            rd2_d = 32'd0;
            ext_d = 32'd0;
            br_d  = 1'b0;
        end else if (bus.en) begin
            rd1_d = fwd1;
            rd2_d = fwd2;
            ext_d = ext;
            br_d  = br;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd1_q <= 32'd0;
            rd2_q <= 32'd0;
            ext_q <= 32'd0;
            br_q  <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            ext_q <= ext_d;
            br_q  <= br_d;
        end
    end

    assign bus.f_rd1         = fwd1;
    assign bus.f_rd2         = fwd2;
    assign bus.ext_b         = ext;
    assign bus.branchAvail   = br;
    assign bus.q_rd1         = rd1_q;
    assign bus.q_rd2         = rd2_q;
    assign bus.q_ext         = ext_q;
    assign bus.q_branchAvail = br_q;
endmodule

`default_nettype wire

// File: tb/tb_branch_ext_forward.sv
// Scoreboard bench for branch_ext_forward: directed cases plus random traffic
// checked against a behavioural model of the decode operand rules.
`default_nettype none

module tb_branch_ext_forward;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_ext_forward_if bif ();
    branch_ext_forward dut (.clk(clk), .rst(rst), .bus(bif.slave));

    typedef struct {
        logic        mem_we;  logic [31:0] mem_wd; logic [4:0] mem_rw;
        logic        wb_we;   logic [31:0] wb_wd;  logic [4:0] wb_rw;
        logic        um, uw;
        logic [4:0]  rs, rt;
        logic [31:0] rd1, rd2;
        logic [15:0] imm;
        logic        extop, exsign;
        logic [2:0]  bt;
        logic        en, flush, rstn;
    } stim_t;

    typedef struct {
        logic [31:0] f1, f2, ext; logic br;
        logic [31:0] q1, q2, qe;  logic qb;
    } exp_t;

    exp_t  sbq[$];
    stim_t prev;
    logic [31:0] m_q1, m_q2, m_qe;
    logic        m_qb;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] m_fwd(stim_t s, logic [4:0] r, logic [31:0] raw);
        if (r == 0) return raw;
        if (s.um && s.mem_we && s.mem_rw == r) return s.mem_wd;
        if (s.uw && s.wb_we && s.wb_rw == r) return s.wb_wd;
        return raw;
    endfunction

    function automatic logic [31:0] m_ext(stim_t s);
        int v;
        if (s.extop) return {s.imm, 16'h0000};
        v = s.exsign ? int'($signed(s.imm)) : int'({16'h0, s.imm});
        return v;
    endfunction

    function automatic logic m_br(stim_t s);
        longint a, b;
        a = longint'($signed(m_fwd(s, s.rs, s.rd1)));
        b = longint'($signed(m_fwd(s, s.rt, s.rd2)));
        case (s.bt)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return a <= 0;
            3'd4: return a > 0;
            3'd5: return a < 0;
            3'd6: return a >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(stim_t s);
        bif.MEM_BACK = {s.mem_we, s.mem_wd, s.mem_rw};
        bif.WB_BACK  = {s.wb_we, s.wb_wd, s.wb_rw};
        bif.USE_MEM_BACK = s.um;  bif.USE_WB_BACK = s.uw;
        bif.rs = s.rs;  bif.rt = s.rt;  bif.rd1 = s.rd1;  bif.rd2 = s.rd2;
        bif.imm = s.imm;  bif.extop = s.extop;  bif.exsign = s.exsign;
        bif.branchType = s.bt;  bif.en = s.en;  bif.flush = s.flush;
        rst = s.rstn;
    endtask

    // One cycle: the edge acts on the previous inputs, then new inputs go out.
    task automatic step(stim_t s);
        exp_t e;
        @(posedge clk);
        if (!prev.rstn || prev.flush) begin
            m_q1 = 0; m_q2 = 0; m_qe = 0; m_qb = 0;
        end else if (prev.en) begin
            m_q1 = m_fwd(prev, prev.rs, prev.rd1);
            m_q2 = m_fwd(prev, prev.rt, prev.rd2);
            m_qe = m_ext(prev);
            m_qb = m_br(prev);
        end
        #1;
        drive(s);
        prev = s;
        e.f1 = m_fwd(s, s.rs, s.rd1);
        e.f2 = m_fwd(s, s.rt, s.rd2);
        e.ext = m_ext(s);
        e.br = m_br(s);
        e.q1 = m_q1; e.q2 = m_q2; e.qe = m_qe; e.qb = m_qb;
        sbq.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("f_rd1", bif.f_rd1, e.f1);
                chk("f_rd2", bif.f_rd2, e.f2);
                chk("ext_b", bif.ext_b, e.ext);
                chk("branchAvail", {31'd0, bif.branchAvail}, {31'd0, e.br});
                chk("q_rd1", bif.q_rd1, e.q1);
                chk("q_rd2", bif.q_rd2, e.q2);
                chk("q_ext", bif.q_ext, e.qe);
                chk("q_branchAvail", {31'd0, bif.q_branchAvail}, {31'd0, e.qb});
            end
        end
    end

    function automatic stim_t base();
        stim_t s;
        s = '{mem_we:0, mem_wd:0, mem_rw:0, wb_we:0, wb_wd:0, wb_rw:0, um:0, uw:0,
              rs:0, rt:0, rd1:0, rd2:0, imm:0, extop:0, exsign:0, bt:0,
              en:0, flush:0, rstn:1};
        return s;
    endfunction

    initial begin : stimulus
        stim_t s;
        m_q1 = 'x; m_q2 = 'x; m_qe = 'x; m_qb = 'x;
        s = base(); s.rstn = 0;
        drive(s); prev = s;
        step(s);
        s.rstn = 1; step(s);

        // Forward priority
        s = base(); s.rs = 5; s.rd1 = 32'h11; s.um = 1; s.uw = 1;
        s.mem_we = 1; s.mem_wd = 32'hAAAA_0000; s.mem_rw = 5;
        s.wb_we = 1;  s.wb_wd = 32'hBBBB_0000;  s.wb_rw = 5;
        step(s);
        s.mem_we = 0; step(s);
        s.uw = 0; step(s);

        // Register zero and rt path
        s = base(); s.um = 1; s.uw = 1; s.mem_we = 1; s.mem_wd = 32'hFFFF_FFFF;
        s.rt = 7; s.wb_we = 1; s.wb_rw = 7; s.wb_wd = 32'h1234;
        step(s);

        // Extension
        s = base(); s.imm = 16'h8001; s.exsign = 1; step(s);
        s.exsign = 0; step(s);
        s.extop = 1; s.exsign = 1; step(s);

        // Branch codes
        s = base(); s.rd1 = 32'h10; s.rd2 = 32'h10;
        s.bt = 1; step(s);
        s.bt = 2; step(s);
        s.rd1 = 32'hFFFF_FFFF;
        for (int t = 3; t <= 6; t++) begin s.bt = 3'(t); step(s); end
        s.rd1 = 0; s.bt = 3; step(s);
        s.bt = 6; step(s);
        s.bt = 7; s.rd1 = 32'h5; s.rd2 = 32'h5; step(s);

        // Branch on forwarded value
        s = base(); s.rs = 3; s.um = 1; s.mem_we = 1; s.mem_rw = 3; s.mem_wd = 5;
        s.bt = 4; step(s);

        // Capture, stall, flush, reset during stall
        s.en = 1; s.imm = 16'hC0DE; s.exsign = 1; step(s);
        s.en = 0; s.rd1 = 32'h77; s.mem_wd = 32'h99; step(s);
        step(s); step(s); step(s);
        s.en = 1; s.flush = 1; step(s);
        s.flush = 0; step(s);
        s.en = 0; step(s);
        s.rstn = 0; step(s);
        s.rstn = 1; step(s); step(s);

        // Random traffic with small register numbers to provoke hits
        for (int i = 0; i < 400; i++) begin
            s.mem_we = 1'($urandom);  s.mem_rw = 5'($urandom_range(0, 3));
            s.mem_wd = $urandom;
            s.wb_we  = 1'($urandom);  s.wb_rw  = 5'($urandom_range(0, 3));
            s.wb_wd  = $urandom;
            s.um = 1'($urandom); s.uw = 1'($urandom);
            s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
            s.rd1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            s.rd2 = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
            s.imm = 16'($urandom); s.extop = 1'($urandom); s.exsign = 1'($urandom);
            s.bt = 3'($urandom);
            s.en = ($urandom_range(0, 2) != 0);
            s.flush = ($urandom_range(0, 7) == 0);
            s.rstn = ($urandom_range(0, 29) != 0);
            step(s);
        end

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/branch_ext_forward.md
# branch_ext_forward

Decode-stage operand unit for the 5-stage MIPS-style pipeline. It resolves register-read hazards by forwarding from the MEM and WB writeback buses, and sign- or zero-extends or upper-loads the 16-bit immediate. It also evaluates the conditional-branch condition on the forwarded operands. Results are available combinationally and in an ID/EX capture register with stall/flush control.

## Interface
- No parameters.
- clk  in  1  clock; all registers update on its rising edge.
- rst  in  1  reset: synchronous, active-low.
- MEM_BACK  in  38  {regWrite[37], Wd[36:5], rw[4:0]} from the MEM stage.
- WB_BACK  in  38  same packing, from the WB stage.
- USE_MEM_BACK  in  1  enables the MEM forwarding source.
- USE_WB_BACK  in  1  enables the WB forwarding source.
- rs, rt  in  5 each  source register numbers (instr[25:21], instr[20:16]).
- rd1, rd2  in  32 each  raw register-file read data for rs and rt.
- imm  in  16  immediate field (instr[15:0]).
- extop  in  1  0 = width extend, 1 = load-upper.
- exsign  in  1  when extop=0: 1 = sign extend, 0 = zero extend.
- branchType  in  3  branch condition select.
- en  in  1  capture enable; 0 = stall (hold).
- flush  in  1  clear the captured stage.
- f_rd1, f_rd2  out  32 each  forwarded operands (combinational).
- ext_b  out  32  extended immediate (combinational).
- branchAvail  out  1  branch condition true (combinational).
- q_rd1, q_rd2, q_ext  out  32 each  registered copies.
- q_branchAvail  out  1  registered copy.

## Operation
- Forwarding for f_rd1; f_rd2 is identical with rt/rd2:
  - MEM hit: USE_MEM_BACK & MEM.regWrite & MEM.rw==rs & rs!=0 -> MEM.Wd.
  - Otherwise WB hit under the same rule -> WB.Wd.
  - Otherwise rd1.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded, so it always reads rd1/rd2 unchanged.
- EXT:
  - extop=1 -> {imm,16'h0000}; exsign is ignored.
  - extop=0, exsign=1 -> {{16{imm[15]}},imm}.
  - extop=0, exsign=0 -> {16'h0,imm}.
- BRANCH (A=f_rd1, B=f_rd2; comparisons are signed, two's complement):
  - 0: none, branchAvail=0.
  - 1: BEQ, A==B.
  - 2: BNE, A!=B.
  - 3: BLEZ, A<=0.
  - 4: BGTZ, A>0.
  - 5: BLTZ, A<0.
  - 6: BGEZ, A>=0.
  - 7: reserved, branchAvail=0.
  - B is ignored for codes 3–6.
- Capture register, priority rst > flush > en:
  - rst=0: all q_* cleared to 0.
  - flush=1: all q_* cleared to 0, regardless of en.
  - en=1: q_* <= {f_rd1, f_rd2, ext_b, branchAvail}.
  - en=0: q_* hold.

## Timing
- Forwarding, extension and branch evaluation are purely combinational within one cycle; there are no internal loops.
- Registered outputs have 1-cycle latency: inputs are sampled on the rising edge, and q_* are valid after that edge.
- Reset takes effect only on a rising edge with rst=0. After release, q_* stay 0 until the first enabled capture.
- Reset asserted mid-stall clears q_* on the next edge.
- Flush on the same edge as en=1 wins; the captured value is 0.

## Test plan
- Forward priority:
  - Stimulus: rs=5, rd1=0x11, MEM_BACK={1,0xAAAA_0000,5}, WB_BACK={1,0xBBBB_0000,5}, both USE=1.
  - Response: f_rd1=0xAAAA_0000.
  - Then set MEM regWrite=0 -> f_rd1=0xBBBB_0000.
  - Then set USE_WB_BACK=0 -> f_rd1=0x11.
- Register-zero and rt path:
  - rs=0, MEM_BACK={1,0xFFFF_FFFF,0}, rd1=0 -> f_rd1=0.
  - rt=7 with WB rw=7, Wd=0x1234 -> f_rd2=0x1234.
- EXT, imm=0x8001:
  - exsign=1, extop=0 -> 0xFFFF_8001.
  - exsign=0, extop=0 -> 0x0000_8001.
  - extop=1 -> 0x8001_0000.
- Branch codes:
  - A=B=0x10: type1 -> 1, type2 -> 0.
  - A=0xFFFF_FFFF: type3 -> 1, type4 -> 0, type5 -> 1, type6 -> 0.
  - A=0: type3 -> 1, type6 -> 1.
  - type7 -> 0.
- Branch on forwarded value:
  - rd1=0, MEM forwards 5 to rs, type4 -> branchAvail=1.
- Register control:
  - rst=0 for one edge -> all q_*=0.
  - en=1 captures the current values; en=0 holds them for 3 cycles.
  - flush=1 with en=1 -> q_*=0 on the next edge.
